// File: rtl/msfsm_barrier_arbiter.sv
// rtl/msfsm_barrier_arbiter.sv - round-robin barrier arbiter for shared FSM1/FSM2 transitions
// Optional watchdog: define MSFSM_BARRIER_TIMEOUT_EN.
module msfsm_barrier_arbiter #(
    parameter int NT    = 8,
    parameter int TMO_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NT-1:0]           fsm1_rdy,
    input  logic [NT-1:0]           fsm2_rdy,
    input  logic [NT-1:0]           ev_req,
    output logic [NT-1:0]           tb_fsm1,
    output logic [NT-1:0]           tb_fsm2,
    output logic                    busy,
    output logic                    fire_vld,
    output logic [$clog2(NT)-1:0]   fire_idx,
    output logic                    err_timeout
);
    localparam int IW = $clog2(NT);
    localparam logic [IW:0]   NT_W = (IW+1)'(NT);
    localparam logic [IW-1:0] LAST = IW'(NT - 1);

    if (NT < 2 || TMO_W < 1) begin : g_bad_param
        $error("msfsm_barrier_arbiter: NT must be >= 2 and TMO_W >= 1");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   idx, idx_n;
    logic [NT-1:0]   tb1_n, tb2_n;
    logic            busy_n, fire_n;
    logic [IW-1:0]   fire_idx_n;

    logic [NT-1:0]   elig;
    logic [NT-1:0]   rot;
    logic [IW:0]     lsh;
    logic [IW:0]     off;
    logic [IW:0]     sum;
    logic [IW-1:0]   sel_idx;
    logic [NT-1:0]   sel_oh;
    logic            sel_found;
    logic [IW-1:0]   idx_inc;

`ifdef MSFSM_BARRIER_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);
    logic [TMO_W-1:0] cnt, cnt_n;
    logic             err_q, err_n;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign elig    = fsm1_rdy & fsm2_rdy & ev_req;
    assign idx_inc = (idx == LAST) ? '0 : idx + IW'(1);

    // Rotate elig so that bit 0 corresponds to ptr; the lowest set bit wins.
    always_comb begin
        lsh       = NT_W - {1'b0, ptr};
        rot       = (elig >> ptr) | (elig << lsh);
        off       = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = (IW+1)'(i);
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= NT_W) begin
            sum = sum - NT_W;
        end
        sel_idx   = sum[IW-1:0];
        sel_oh    = NT'(1) << sel_idx;
        sel_found = |elig;
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        idx_n      = idx;
        tb1_n      = tb_fsm1;
        tb2_n      = tb_fsm2;
        fire_n     = 1'b0;
        fire_idx_n = fire_idx;
`ifdef MSFSM_BARRIER_TIMEOUT_EN
        cnt_n      = cnt;
        err_n      = err_q;
`endif
        case (state)
            IDLE: begin
                tb1_n = '0;
                tb2_n = '0;
                if (sel_found) begin
                    state_n = GRANT;
                    idx_n   = sel_idx;
                    tb1_n   = sel_oh;
                    tb2_n   = sel_oh;
`ifdef MSFSM_BARRIER_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            GRANT: begin
                // Each side releases independently; ev_req is deliberately ignored here.
                tb1_n = tb_fsm1 & fsm1_rdy;
                tb2_n = tb_fsm2 & fsm2_rdy;
                if (tb1_n == '0 && tb2_n == '0) begin
                    state_n    = IDLE;
                    fire_n     = 1'b1;
                    fire_idx_n = idx;
                    ptr_n      = idx_inc;
                end
`ifdef MSFSM_BARRIER_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    tb1_n   = '0;
                    tb2_n   = '0;
                    state_n = IDLE;
                    ptr_n   = idx_inc;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + TMO_W'(1);
                end
`endif
            end
            default: begin
                state_n = IDLE;
                tb1_n   = '0;
                tb2_n   = '0;
            end
        endcase
        busy_n = (state_n == GRANT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            tb_fsm1  <= '0;
            tb_fsm2  <= '0;
            busy     <= 1'b0;
            fire_vld <= 1'b0;
            fire_idx <= '0;
`ifdef MSFSM_BARRIER_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            idx      <= idx_n;
            tb_fsm1  <= tb1_n;
            tb_fsm2  <= tb2_n;
            busy     <= busy_n;
            fire_vld <= fire_n;
            fire_idx <= fire_idx_n;
`ifdef MSFSM_BARRIER_TIMEOUT_EN
            cnt      <= cnt_n;
            err_q    <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_msfsm_barrier_arbiter.sv
// tb/tb_msfsm_barrier_arbiter.sv - self-checking bench for msfsm_barrier_arbiter
module tb_msfsm_barrier_arbiter;
    localparam int NT = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NT-1:0] fsm1_rdy, fsm2_rdy, ev_req;
    logic [NT-1:0] tb_fsm1, tb_fsm2;
    logic          busy, fire_vld, err_timeout;
    logic [2:0]    fire_idx;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] tb1;
        logic [7:0] tb2;
        logic       busy;
        logic       fire;
        logic [2:0] idx;
        logic       err;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [7:0] r1, r2, ev;
        logic [7:0] tb1, tb2;
        logic       busy, fire;
        logic [2:0] idx;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];

    msfsm_barrier_arbiter #(.NT(NT), .TMO_W(4)) dut (
        .clk(clk), .reset(reset),
        .fsm1_rdy(fsm1_rdy), .fsm2_rdy(fsm2_rdy), .ev_req(ev_req),
        .tb_fsm1(tb_fsm1), .tb_fsm2(tb_fsm2),
        .busy(busy), .fire_vld(fire_vld), .fire_idx(fire_idx),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] t1, input logic [7:0] t2, input logic b,
                                input logic f, input logic [2:0] i, input logic e);
        exp_t x;
        x.tb1 = t1; x.tb2 = t2; x.busy = b; x.fire = f; x.idx = i; x.err = e;
        return x;
    endfunction

    task automatic check_out(input string nm);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sbq.pop_front();
        if (tb_fsm1 !== e.tb1 || tb_fsm2 !== e.tb2 || busy !== e.busy ||
            fire_vld !== e.fire || err_timeout !== e.err || (e.fire && fire_idx !== e.idx)) begin
            errors++;
            $display("FAIL %s: got tb1=%h tb2=%h busy=%b fire=%b idx=%0d err=%b, expected tb1=%h tb2=%h busy=%b fire=%b idx=%0d err=%b",
                     nm, tb_fsm1, tb_fsm2, busy, fire_vld, fire_idx, err_timeout,
                     e.tb1, e.tb2, e.busy, e.fire, e.idx, e.err);
        end
    endtask

    task automatic step(input string nm, input logic rst, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] ev, input exp_t e);
        reset    = rst;
        fsm1_rdy = r1;
        fsm2_rdy = r2;
        ev_req   = ev;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; fsm1_rdy = '0; fsm2_rdy = '0; ev_req = '0;

        // rst, r1, r2, ev, tb1, tb2, busy, fire, idx
        vecs.push_back('{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h04, 8'h04, 8'h00, 8'h04, 8'h04, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd2});
        vecs.push_back('{1'b0, 8'h22, 8'h22, 8'h22, 8'h20, 8'h20, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h02, 8'h22, 8'h22, 8'h00, 8'h20, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h02, 8'h02, 8'h22, 8'h00, 8'h00, 1'b0, 1'b1, 3'd5});
        vecs.push_back('{1'b0, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd1});
        vecs.push_back('{1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0});
        vecs.push_back('{1'b0, 8'h18, 8'h18, 8'h18, 8'h08, 8'h08, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h18, 8'h18, 8'h18, 8'h08, 8'h08, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 3'd3});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4});
        vecs.push_back('{1'b0, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b1, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h81, 8'h81, 8'h81, 8'h01, 8'h01, 1'b1, 1'b0, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0});

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].r1, vecs[i].r2, vecs[i].ev,
                 mk(vecs[i].tb1, vecs[i].tb2, vecs[i].busy, vecs[i].fire, vecs[i].idx, 1'b0));
        end

        // Watchdog corner: grant on bit 3, rdy held high, ev_req dropped after the request.
        step("tmo_grant", 1'b0, 8'h08, 8'h08, 8'h08, mk(8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 1'b0));
        for (int c = 2; c <= 100; c++) begin
`ifdef MSFSM_BARRIER_TIMEOUT_EN
            if (c <= 15)
                step($sformatf("tmo_c%0d", c), 1'b0, 8'h08, 8'h08, 8'h00,
                     mk(8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 1'b0));
            else
                step($sformatf("tmo_c%0d", c), 1'b0, 8'h08, 8'h08, 8'h00,
                     mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1));
`else
            step($sformatf("tmo_c%0d", c), 1'b0, 8'h08, 8'h08, 8'h00,
                 mk(8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 1'b0));
`endif
        end
        step("tmo_reset", 1'b1, 8'h00, 8'h00, 8'h00, mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
        step("tmo_after", 1'b0, 8'h00, 8'h00, 8'h00, mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));

        // Random traffic: grant exclusivity and busy/fire consistency every cycle.
        for (int n = 0; n < 10000; n++) begin
            reset    = 1'b0;
            fsm1_rdy = 8'($urandom);
            fsm2_rdy = 8'($urandom);
            ev_req   = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ($countones(tb_fsm1 | tb_fsm2) > 1 || busy !== ((tb_fsm1 | tb_fsm2) != '0) ||
                (fire_vld && busy)) begin
                errors++;
                $display("FAIL excl_%0d: got tb1=%h tb2=%h busy=%b fire=%b, expected at most one grant bit, busy equal to any grant, no fire while busy",
                         n, tb_fsm1, tb_fsm2, busy, fire_vld);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
